// File: rtl/evm.sv
`default_nettype none
// ============================================================================
// Module      : evm
// Description : Electronic voting machine controller for three candidates.
//               Admits one voter at a time through a ready/vote handshake,
//               keeps a saturating 7-bit vote counter per candidate and, once
//               the poll is closed, shows a selected count or the winner.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               vote_candidate_1..3      - debounced vote push buttons
//               switch_on_evm            - machine enable (0 forces IDLE)
//               candidate_ready          - voter admitted by the officer
//               voting_session_done      - close the poll
//               display_results[1:0]     - count select (00 none, 01..11)
//               display_winner           - show winner (overrides select)
//               candidate_name[1:0]      - displayed candidate index
//               results[6:0]             - displayed vote count
//               invalid_results          - winner request is ambiguous
//               voting_in_progress       - LED, vote pending
//               voting_done              - LED, poll closed
// Revision    : 1.0 - initial release
// ============================================================================
module evm (
    input  logic       clk,
    input  logic       rst,
    input  logic       vote_candidate_1,
    input  logic       vote_candidate_2,
    input  logic       vote_candidate_3,
    input  logic       switch_on_evm,
    input  logic       candidate_ready,
    input  logic       voting_session_done,
    input  logic [1:0] display_results,
    input  logic       display_winner,
    output logic [1:0] candidate_name,
    output logic [6:0] results,
    output logic       invalid_results,
    output logic       voting_in_progress,
    output logic       voting_done
);

    localparam logic [2:0] c_IDLE           = 3'b000;
    localparam logic [2:0] c_WAIT_CANDIDATE = 3'b001;
    localparam logic [2:0] c_WAIT_VOTE      = 3'b010;
    localparam logic [2:0] c_VOTED          = 3'b011;
    localparam logic [2:0] c_DONE           = 3'b100;

    localparam logic [6:0] c_COUNT_MAX = 7'd127;

    logic [2:0] current_state;
    logic [6:0] candidate_1_vote_count;
    logic [6:0] candidate_2_vote_count;
    logic [6:0] candidate_3_vote_count;

    logic [2:0] w_buttons;
    logic       w_no_press;
    logic       w_one_press;
    logic       w_win_1;
    logic       w_win_2;
    logic       w_win_3;
    logic [6:0] w_sel_count;

    assign w_buttons   = {vote_candidate_3, vote_candidate_2, vote_candidate_1};
    assign w_no_press  = (w_buttons == 3'b000);
    assign w_one_press = (w_buttons == 3'b001) || (w_buttons == 3'b010) ||
                         (w_buttons == 3'b100);

    // Strict maxima: a tie for the top (or all zero) leaves every w_win_* low.
    assign w_win_1 = (candidate_1_vote_count > candidate_2_vote_count) &&
                     (candidate_1_vote_count > candidate_3_vote_count);
    assign w_win_2 = (candidate_2_vote_count > candidate_1_vote_count) &&
                     (candidate_2_vote_count > candidate_3_vote_count);
    assign w_win_3 = (candidate_3_vote_count > candidate_1_vote_count) &&
                     (candidate_3_vote_count > candidate_2_vote_count);

    always_comb begin
        w_sel_count = 7'd0;
        case (display_results)
            2'b01:   w_sel_count = candidate_1_vote_count;
            2'b10:   w_sel_count = candidate_2_vote_count;
            2'b11:   w_sel_count = candidate_3_vote_count;
            default: w_sel_count = 7'd0;
        endcase
    end

    // Control state machine and vote counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            current_state          <= c_IDLE;
            candidate_1_vote_count <= 7'd0;
            candidate_2_vote_count <= 7'd0;
            candidate_3_vote_count <= 7'd0;
        end else if (!switch_on_evm) begin
            // Powering down keeps the tallies; only rst clears them.
            current_state <= c_IDLE;
        end else begin
            case (current_state)
                c_IDLE: current_state <= c_WAIT_CANDIDATE;
                c_WAIT_CANDIDATE: begin
                    if (voting_session_done)
                        current_state <= c_DONE;
                    else if (candidate_ready && w_no_press)
                        current_state <= c_WAIT_VOTE;
                end
                c_WAIT_VOTE: begin
                    if (voting_session_done) begin
                        current_state <= c_DONE;
                    end else if (w_one_press) begin
                        // Leaving WAIT_VOTE is what makes a held button count once.
                        current_state <= c_VOTED;
                        if (vote_candidate_1 && candidate_1_vote_count != c_COUNT_MAX)
                            candidate_1_vote_count <= candidate_1_vote_count + 7'd1;
                        if (vote_candidate_2 && candidate_2_vote_count != c_COUNT_MAX)
                            candidate_2_vote_count <= candidate_2_vote_count + 7'd1;
                        if (vote_candidate_3 && candidate_3_vote_count != c_COUNT_MAX)
                            candidate_3_vote_count <= candidate_3_vote_count + 7'd1;
                    end
                end
                c_VOTED: current_state <= c_WAIT_CANDIDATE;
                c_DONE:  current_state <= c_DONE;
                default: current_state <= c_IDLE;
            endcase
        end
    end

    // Registered display: sampled from the state and selectors before the edge.
    always_ff @(posedge clk) begin
        if (rst || current_state != c_DONE) begin
            candidate_name  <= 2'b00;
            results         <= 7'd0;
            invalid_results <= 1'b0;
        end else if (display_winner) begin
            invalid_results <= 1'b0;
            if (w_win_1) begin
                candidate_name <= 2'b01;
                results        <= candidate_1_vote_count;
            end else if (w_win_2) begin
                candidate_name <= 2'b10;
                results        <= candidate_2_vote_count;
            end else if (w_win_3) begin
                candidate_name <= 2'b11;
                results        <= candidate_3_vote_count;
            end else begin
                candidate_name  <= 2'b00;
                results         <= 7'd0;
                invalid_results <= 1'b1;
            end
        end else begin
            candidate_name  <= display_results;
            results         <= w_sel_count;
            invalid_results <= 1'b0;
        end
    end

    assign voting_in_progress = (current_state == c_WAIT_VOTE);
    assign voting_done        = (current_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_evm.sv
`default_nettype none
// ============================================================================
// Module      : tb_evm
// Description : Self-checking bench for evm. A behavioural model of the voting
//               rules is compared against every DUT output on each falling
//               edge; directed scenarios add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_evm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vote_candidate_1 = 1'b0;
    logic       vote_candidate_2 = 1'b0;
    logic       vote_candidate_3 = 1'b0;
    logic       switch_on_evm = 1'b0;
    logic       candidate_ready = 1'b0;
    logic       voting_session_done = 1'b0;
    logic [1:0] display_results = 2'b00;
    logic       display_winner = 1'b0;
    logic [1:0] candidate_name;
    logic [6:0] results;
    logic       invalid_results;
    logic       voting_in_progress;
    logic       voting_done;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    evm dut (
        .clk                 (clk),
        .rst                 (rst),
        .vote_candidate_1    (vote_candidate_1),
        .vote_candidate_2    (vote_candidate_2),
        .vote_candidate_3    (vote_candidate_3),
        .switch_on_evm       (switch_on_evm),
        .candidate_ready     (candidate_ready),
        .voting_session_done (voting_session_done),
        .display_results     (display_results),
        .display_winner      (display_winner),
        .candidate_name      (candidate_name),
        .results             (results),
        .invalid_results     (invalid_results),
        .voting_in_progress  (voting_in_progress),
        .voting_done         (voting_done)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Phases: 0 powered off, 1 awaiting voter, 2 voter admitted,
    //         3 vote just taken, 4 poll closed.
    int m_phase = 0;
    int m_cnt[3] = '{0, 0, 0};
    int m_name = 0;
    int m_res  = 0;
    int m_inv  = 0;

    always @(posedge clk) begin
        int presses;
        int mx, nmx, wi;
        presses = int'(vote_candidate_1) + int'(vote_candidate_2) + int'(vote_candidate_3);
        if (rst) begin
            m_phase = 0;
            m_cnt   = '{0, 0, 0};
            m_name  = 0; m_res = 0; m_inv = 0;
        end else begin
            // Display reflects the phase and selectors before this edge.
            m_name = 0; m_res = 0; m_inv = 0;
            if (m_phase == 4) begin
                if (display_winner) begin
                    mx = 0; nmx = 0; wi = 0;
                    for (int i = 0; i < 3; i++) begin
                        if (m_cnt[i] > mx) begin
                            mx = m_cnt[i]; nmx = 1; wi = i + 1;
                        end else if (m_cnt[i] == mx && mx > 0) begin
                            nmx++;
                        end
                    end
                    if (mx > 0 && nmx == 1) begin
                        m_name = wi; m_res = mx;
                    end else begin
                        m_inv = 1;
                    end
                end else begin
                    m_name = int'(display_results);
                    m_res  = (display_results == 2'b00) ? 0 : m_cnt[int'(display_results) - 1];
                end
            end
            if (!switch_on_evm) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (voting_session_done)                  m_phase = 4;
                else if (candidate_ready && presses == 0) m_phase = 2;
            end else if (m_phase == 2) begin
                if (voting_session_done) begin
                    m_phase = 4;
                end else if (presses == 1) begin
                    if (vote_candidate_1) m_cnt[0] = (m_cnt[0] >= 127) ? 127 : m_cnt[0] + 1;
                    if (vote_candidate_2) m_cnt[1] = (m_cnt[1] >= 127) ? 127 : m_cnt[1] + 1;
                    if (vote_candidate_3) m_cnt[2] = (m_cnt[2] >= 127) ? 127 : m_cnt[2] + 1;
                    m_phase = 3;
                end
            end else if (m_phase == 3) begin
                m_phase = 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_in_progress", int'(voting_in_progress), (m_phase == 2) ? 1 : 0);
            check("model_done",        int'(voting_done),        (m_phase == 4) ? 1 : 0);
            check("model_name",        int'(candidate_name),     m_name);
            check("model_results",     int'(results),            m_res);
            check("model_invalid",     int'(invalid_results),    m_inv);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k, input bit v);
        if (k == 1) vote_candidate_1 = v;
        if (k == 2) vote_candidate_2 = v;
        if (k == 3) vote_candidate_3 = v;
    endtask

    // Admit a voter, press button k for two cycles, release.
    task automatic cast(input int k);
        candidate_ready = 1'b1; step(1);
        candidate_ready = 1'b0;
        press(k, 1'b1); step(2);
        press(k, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; step(1);
        rst = 1'b0;
    endtask

    task automatic close_and_show(input logic [1:0] sel, input bit win);
        display_results = sel; display_winner = win;
        step(1);
    endtask

    initial begin
        // Reset then power-up.
        switch_on_evm = 1'b0;
        do_reset();
        chk_en = 1'b1;
        check("rst_name", int'(candidate_name), 0);
        check("rst_results", int'(results), 0);
        check("rst_done_led", int'(voting_done), 0);
        switch_on_evm = 1'b1; step(1);
        check("pwr_in_progress", int'(voting_in_progress), 0);

        // Single vote with the button held three cycles.
        candidate_ready = 1'b1; step(1);
        candidate_ready = 1'b0;
        check("ready_in_progress", int'(voting_in_progress), 1);
        vote_candidate_1 = 1'b1; step(3);
        vote_candidate_1 = 1'b0;
        check("held_vote_in_progress", int'(voting_in_progress), 0);

        // Invalid double press, then a valid press.
        candidate_ready = 1'b1; step(1);
        candidate_ready = 1'b0;
        vote_candidate_2 = 1'b1; vote_candidate_3 = 1'b1; step(2);
        check("double_press_still_waiting", int'(voting_in_progress), 1);
        vote_candidate_3 = 1'b0; step(2);
        vote_candidate_2 = 1'b0;
        check("single_press_taken", int'(voting_in_progress), 0);

        // Reset while a voter is admitted.
        candidate_ready = 1'b1; step(1);
        candidate_ready = 1'b0;
        do_reset();
        check("midvote_rst_in_progress", int'(voting_in_progress), 0);

        // Full session: C1=2, C2=3, C3=3.
        step(1);
        cast(1); cast(2); cast(3); cast(2); cast(1); cast(2); cast(3); cast(3);
        voting_session_done = 1'b1; step(1);
        check("session_done_led", int'(voting_done), 1);
        close_and_show(2'b01, 1'b0);
        check("show_c1_name", int'(candidate_name), 1);
        check("show_c1_count", int'(results), 2);
        close_and_show(2'b11, 1'b0);
        check("show_c3_name", int'(candidate_name), 3);
        check("show_c3_count", int'(results), 3);
        close_and_show(2'b00, 1'b1);
        check("tie_invalid", int'(invalid_results), 1);
        check("tie_name", int'(candidate_name), 0);

        // Winner: votes 2, 2, 1.
        display_winner = 1'b0; voting_session_done = 1'b0;
        do_reset(); step(1);
        cast(2); cast(2); cast(1);
        voting_session_done = 1'b1; step(2);
        close_and_show(2'b00, 1'b1);
        check("winner_name", int'(candidate_name), 2);
        check("winner_count", int'(results), 2);
        check("winner_invalid", int'(invalid_results), 0);

        // Power off in DONE, then back on: tallies retained.
        display_winner = 1'b0; display_results = 2'b10;
        switch_on_evm = 1'b0; step(2);
        check("off_results", int'(results), 0);
        check("off_done_led", int'(voting_done), 0);
        switch_on_evm = 1'b1; step(3);
        check("retained_c2", int'(results), 2);

        // Zero votes: winner request is invalid.
        do_reset(); step(2);
        close_and_show(2'b00, 1'b1);
        check("zero_votes_invalid", int'(invalid_results), 1);

        // Saturation at 127, then a close that abandons a pending press.
        display_winner = 1'b0; voting_session_done = 1'b0;
        do_reset(); step(1);
        for (int i = 0; i < 128; i++) cast(3);
        candidate_ready = 1'b1; step(1);
        candidate_ready = 1'b0;
        vote_candidate_3 = 1'b1; voting_session_done = 1'b1; step(1);
        vote_candidate_3 = 1'b0;
        check("abandon_done_led", int'(voting_done), 1);
        close_and_show(2'b11, 1'b0);
        check("saturated_c3", int'(results), 127);
        close_and_show(2'b00, 1'b1);
        check("saturated_winner", int'(candidate_name), 3);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
